// File: rtl/cmp_location_scheduler_if.sv
// rtl/cmp_location_scheduler_if.sv - control, beat stream and result bundle for cmp_location_scheduler
// CMP_LOCATION_ZDROP_EN adds zdrop_thr and zdropped.
interface cmp_location_scheduler_if #(
  parameter int CMP_WIDTH      = 16,
  parameter int LOCATION_WIDTH = 32,
  parameter int LEN_WIDTH      = 16
);
  logic                      start;
  logic [LEN_WIDTH-1:0]      len;
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [CMP_WIDTH-1:0]      in_score;
  logic [LOCATION_WIDTH-1:0] in_loc;
  logic                      busy;
  logic                      done;
  logic [CMP_WIDTH-1:0]      max_score;
  logic [LOCATION_WIDTH-1:0] max_loc;
  logic [LEN_WIDTH-1:0]      beat_cnt;
`ifdef CMP_LOCATION_ZDROP_EN
  logic [CMP_WIDTH-1:0]      zdrop_thr;
  logic                      zdropped;

  modport master (
    output start, len, flush, in_valid, in_score, in_loc, zdrop_thr,
    input  in_ready, busy, done, max_score, max_loc, beat_cnt, zdropped
  );
  modport slave (
    input  start, len, flush, in_valid, in_score, in_loc, zdrop_thr,
    output in_ready, busy, done, max_score, max_loc, beat_cnt, zdropped
  );
`else
  modport master (
    output start, len, flush, in_valid, in_score, in_loc,
    input  in_ready, busy, done, max_score, max_loc, beat_cnt
  );
  modport slave (
    input  start, len, flush, in_valid, in_score, in_loc,
    output in_ready, busy, done, max_score, max_loc, beat_cnt
  );
`endif
endinterface

// File: rtl/cmp_location_scheduler.sv
// rtl/cmp_location_scheduler.sv - running signed max/location over a len-beat stream with done pulse
// Optional early termination on score drop-off under CMP_LOCATION_ZDROP_EN.
module cmp_location_scheduler #(
  parameter int CMP_WIDTH      = 16,
  parameter int LOCATION_WIDTH = 32,
  parameter int LEN_WIDTH      = 16
) (
  input logic                     clk,
  input logic                     rst,
  cmp_location_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CMP_WIDTH-1:0] SCORE_MIN = {1'b1, {(CMP_WIDTH-1){1'b0}}};
  localparam logic [LEN_WIDTH-1:0] CNT_ONE   = LEN_WIDTH'(1);

  state_t                    state;
  logic                      in_ready_q;
  logic                      busy_q;
  logic                      done_q;
  logic [CMP_WIDTH-1:0]      max_score_q;
  logic [LOCATION_WIDTH-1:0] max_loc_q;
  logic [LEN_WIDTH-1:0]      beat_cnt_q;
  logic [LEN_WIDTH-1:0]      len_q;
  logic                      accept;
  logic                      last_beat;
  logic                      score_ge;
  logic                      zd_hit;
  logic                      stop_run;

  // flush must block the beat and any pulse in the same cycle it is raised
  assign bus.in_ready  = in_ready_q & ~bus.flush;
  assign bus.done      = done_q & ~bus.flush;
  assign bus.busy      = busy_q;
  assign bus.max_score = max_score_q;
  assign bus.max_loc   = max_loc_q;
  assign bus.beat_cnt  = beat_cnt_q;

  assign accept    = bus.in_valid & bus.in_ready;
  assign last_beat = (beat_cnt_q + CNT_ONE) == len_q;
  assign score_ge  = $signed(bus.in_score) >= $signed(max_score_q);

`ifdef CMP_LOCATION_ZDROP_EN
  logic                 zdropped_q;
  logic signed [CMP_WIDTH:0] zd_diff;

  // one extra bit so max - score can never overflow
  assign zd_diff = $signed({max_score_q[CMP_WIDTH-1], max_score_q})
                 - $signed({bus.in_score[CMP_WIDTH-1], bus.in_score});
  assign zd_hit  = zd_diff > $signed({1'b0, bus.zdrop_thr});
  assign bus.zdropped = zdropped_q;
`else
  assign zd_hit = 1'b0;
`endif

  assign stop_run = last_beat | zd_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      max_score_q <= SCORE_MIN;
      max_loc_q   <= '0;
      beat_cnt_q  <= '0;
      len_q       <= '0;
`ifdef CMP_LOCATION_ZDROP_EN
      zdropped_q  <= 1'b0;
`endif
    end else if (bus.flush) begin
      state      <= IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q       <= bus.len;
            max_score_q <= SCORE_MIN;
            max_loc_q   <= '0;
            beat_cnt_q  <= '0;
            busy_q      <= 1'b1;
`ifdef CMP_LOCATION_ZDROP_EN
            zdropped_q  <= 1'b0;
`endif
            if (bus.len == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state      <= RUN;
              in_ready_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            // >= lets the newer beat win a tie
            if (score_ge) begin
              max_score_q <= bus.in_score;
              max_loc_q   <= bus.in_loc;
            end
            beat_cnt_q <= beat_cnt_q + CNT_ONE;
            if (stop_run) begin
              state      <= DONE;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
`ifdef CMP_LOCATION_ZDROP_EN
              if (zd_hit) zdropped_q <= 1'b1;
`endif
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_location_scheduler.sv
// tb/tb_cmp_location_scheduler.sv - scoreboard bench for cmp_location_scheduler
// Honours CMP_LOCATION_ZDROP_EN when defined.
module tb_cmp_location_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  cmp_location_scheduler_if bus ();

  cmp_location_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef CMP_LOCATION_ZDROP_EN
  localparam bit ZD_EN = 1'b1;
`else
  localparam bit ZD_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] sc;
    logic [31:0] loc;
    logic [15:0] cnt;
    bit          zd;
  } exp_t;

  exp_t        exp_q[$];
  int          s_arr[$];
  logic [31:0] l_arr[$];
  bit          vpat[$];
  int          zthr = 65535;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_acc_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain running maximum over the first n beats, newer wins ties.
  function automatic exp_t model(input int n);
    exp_t e;
    int   best = -32768;
    e.loc = '0;
    e.cnt = '0;
    e.zd  = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.cnt = e.cnt + 16'd1;
      if (ZD_EN && (best - s_arr[i]) > zthr) begin
        e.zd = 1'b1;
        break;
      end
      if (s_arr[i] >= best) begin
        best  = s_arr[i];
        e.loc = l_arr[i];
      end
    end
    e.sc = 16'(best);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      exp_t e;
      done_cnt++;
      done_cyc = cyc;
      check("done_has_expect", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("max_score", 64'(bus.max_score), 64'(e.sc));
        check("max_loc", 64'(bus.max_loc), 64'(e.loc));
        check("beat_cnt", 64'(bus.beat_cnt), 64'(e.cnt));
`ifdef CMP_LOCATION_ZDROP_EN
        check("zdropped", 64'(bus.zdropped), 64'(e.zd));
`endif
      end
    end
  end

  function automatic bit next_valid(input int pct);
    if (vpat.size() > 0) return vpat.pop_front();
    return $urandom_range(99) < pct;
  endfunction

  // Caller is at posedge+1. flush_at >= 0 aborts after that many accepts.
  task automatic run_stream(input int n, input int pct, input int flush_at);
    exp_t e;
    int   acc = 0;
    int   budget = 0;
    int   d0 = done_cnt;
`ifdef CMP_LOCATION_ZDROP_EN
    bus.zdrop_thr = 16'(zthr);
`endif
    e = model(n);
    if (flush_at < 0) exp_q.push_back(e);
    bus.start = 1'b1;
    bus.len   = 16'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (done_cnt == d0 && budget < 400) begin
      if (flush_at >= 0 && acc == flush_at) begin
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_score = 16'(s_arr[acc]);
        bus.in_loc   = l_arr[acc];
        @(negedge clk);
        check("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        break;
      end
      if (acc < n) begin
        bus.in_valid = next_valid(pct);
        bus.in_score = 16'(s_arr[acc]);
        bus.in_loc   = l_arr[acc];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        acc++;
        last_acc_cyc = cyc;
      end
      @(posedge clk); #1;
      budget++;
    end
    bus.in_valid = 1'b0;
    vpat.delete();
    if (flush_at < 0) begin
      check("done_seen", 64'(done_cnt != d0), 64'd1);
      check("accept_count", 64'(acc), 64'(e.cnt));
      if (n > 0 && done_cnt != d0)
        check("done_latency", 64'(done_cyc - last_acc_cyc), 64'd1);
      @(negedge clk);
      check("done_one_cycle", 64'(bus.done), 64'd0);
      check("busy_after_done", 64'(bus.busy), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic load(input int n, input int mode);
    logic [15:0] r;
    s_arr.delete();
    l_arr.delete();
    for (int i = 0; i < n; i++) begin
      r = 16'($urandom);
      if (mode == 0) s_arr.push_back(int'($signed(r)));
      else s_arr.push_back($urandom_range(4) - 2);
      l_arr.push_back($urandom);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   d0;
    bus.start = 0; bus.len = 0; bus.flush = 0;
    bus.in_valid = 0; bus.in_score = 0; bus.in_loc = 0;
`ifdef CMP_LOCATION_ZDROP_EN
    bus.zdrop_thr = 16'hffff;
`endif
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_max_score", 64'(bus.max_score), 64'h8000);
    check("rst_max_loc", 64'(bus.max_loc), 64'd0);
    check("rst_beat_cnt", 64'(bus.beat_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    s_arr = '{5, -3, 12, 7};       l_arr = '{10, 11, 12, 13};
    run_stream(4, 100, -1);
    s_arr = '{9, 9, 2};            l_arr = '{1, 2, 3};
    run_stream(3, 100, -1);
    s_arr = '{-32768, -32768};     l_arr = '{7, 8};
    run_stream(2, 100, -1);
    run_stream(0, 100, -1);

    d0 = done_cnt;
    s_arr = '{4, 1, 6};            l_arr = '{21, 22, 23};
    vpat = '{1, 0, 0, 1, 0, 1};
    run_stream(3, 100, -1);
    check("stall_done_once", 64'(done_cnt - d0), 64'd1);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("beyond_len_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    s_arr = '{3, 8, -1, 20, 2};    l_arr = '{31, 32, 33, 34, 35};
    d0 = done_cnt;
    run_stream(5, 100, 2);
    e = model(2);
    @(negedge clk);
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_beat_cnt", 64'(bus.beat_cnt), 64'(e.cnt));
    check("flush_max_score", 64'(bus.max_score), 64'(e.sc));
    check("flush_max_loc", 64'(bus.max_loc), 64'(e.loc));
    repeat (4) @(posedge clk);
    #1;
    check("flush_no_done", 64'(done_cnt - d0), 64'd0);

    bus.start = 1'b1; bus.flush = 1'b1; bus.len = 16'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("start_flush_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;

    bus.start = 1'b1; bus.len = 16'd5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_score = 16'd50; bus.in_loc = 32'd99;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", 64'(bus.in_ready), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_max_score", 64'(bus.max_score), 64'h8000);
    check("arst_max_loc", 64'(bus.max_loc), 64'd0);
    check("arst_beat_cnt", 64'(bus.beat_cnt), 64'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef CMP_LOCATION_ZDROP_EN
    zthr = 10;
    s_arr = '{20, 15, 8, 30, 1, 2}; l_arr = '{1, 2, 3, 4, 5, 6};
    run_stream(6, 100, -1);
    zthr = 65535;
`endif

    for (int r = 0; r < 12; r++) begin
      load($urandom_range(8, 1), r % 2);
      if (ZD_EN) zthr = (r % 3 == 0) ? $urandom_range(5, 0) : 65535;
      run_stream(s_arr.size(), $urandom_range(100, 30), -1);
    end
    zthr = 65535;

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
